// File: rtl/uart_tx_pkg.sv
// Purpose: shared types and constants for the PIO-style UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, register addresses, status bit indices, frame width.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_DONE   = 2'd3;

   localparam int STAT_BUSY       = 0;
   localparam int STAT_HOLD_EMPTY = 1;
   localparam int STAT_OVERRUN    = 2;

   localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_pio_if.sv
// Purpose: Avalon-MM slave register bus of the UART transmitter.
// Latency: reads return on readdata one clock after address is presented.
// Backpressure: none; every access completes in one cycle.
// Signals: address, chipselect, write_n, writedata (master drives), readdata (slave drives).
interface uart_tx_pio_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );
endinterface

// File: rtl/uart_tx_serializer.sv
// Purpose: 8N1 serializer: start bit, 8 data bits LSB first, stop bit.
// Latency: tx drops to the start bit at the edge that accepts a byte; frame is 10*CLKS_PER_BIT cycles.
// Backpressure: ld_rdy is high only in IDLE; a byte is taken on ld_vld & ld_rdy.
// Ports: clk, reset (sync, active-high), ld_vld/ld_dat/ld_rdy load handshake, busy, done (1-cycle pulse at frame end), tx.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ld_vld,
   input  logic [DATA_BITS-1:0] ld_dat,
   output logic                 ld_rdy,
   output logic                 busy,
   output logic                 done,
   output logic                 tx
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]  BIT_LAST  = 3'(DATA_BITS - 1);

   tx_state_t            state_q, state_d;
   logic [15:0]          baud_q, baud_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 tx_q, tx_d;
   logic                 bit_end;

   assign bit_end = (baud_q == BAUD_LAST);
   assign ld_rdy  = (state_q == ST_IDLE);
   assign busy    = (state_q != ST_IDLE);
   assign tx      = tx_q;

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      done    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            baud_d = '0;
            bit_d  = '0;
            if (ld_vld) begin
               state_d = ST_START;
               shift_d = ld_dat;
               tx_d    = 1'b0;
            end
         end
         ST_START: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               baud_d  = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BIT_LAST) begin
                  bit_d   = '0;
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 3'd1;
                  // Next bit is shift_q[1] because the shift lands on this same edge.
                  tx_d  = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               baud_d  = '0;
               state_d = ST_IDLE;
               tx_d    = 1'b1;
               done    = 1'b1;
            end else begin
               baud_d = baud_q + 16'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/uart_tx_pio.sv
// Purpose: Avalon-MM UART transmitter: holding register, sticky status flags, serializer.
// Latency: readdata is registered (1 cycle); a byte written while idle starts its frame one edge later.
// Backpressure: none on the bus; a write into a full holding register is dropped and flags overrun.
// Ports: clk, reset (sync, active-high), bus (Avalon slave modport), out_port (serial line, idle high).
module uart_tx_pio
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic         clk,
   input  logic         reset,
   uart_tx_pio_if.slave bus,
   output logic         out_port
);

   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic                 hold_full_q, hold_full_d;
   logic                 overrun_q, overrun_d;
   logic                 done_q, done_d;
   logic [31:0]          readdata_q, readdata_d;

   logic ld_rdy, ser_busy, ser_done;
   logic wr_stb, xfer;
   logic unused_wd;

   assign unused_wd    = ^bus.writedata[31:8];
   assign wr_stb       = bus.chipselect & ~bus.write_n;
   assign xfer         = hold_full_q & ld_rdy;
   assign bus.readdata = readdata_q;

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk    (clk),
      .reset  (reset),
      .ld_vld (hold_full_q),
      .ld_dat (hold_q),
      .ld_rdy (ld_rdy),
      .busy   (ser_busy),
      .done   (ser_done),
      .tx     (out_port)
   );

   always_comb begin
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      overrun_d   = overrun_q;
      done_d      = done_q | ser_done;
      if (xfer) begin
         hold_full_d = 1'b0;
      end
      // A slot freed by a transfer on this same edge can take the new byte.
      if (wr_stb && bus.address == ADDR_DATA) begin
         if (!hold_full_q || xfer) begin
            hold_d      = bus.writedata[DATA_BITS-1:0];
            hold_full_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      // Clears are applied last so they win over a set on the same edge.
      if (wr_stb && bus.address == ADDR_STATUS && bus.writedata[STAT_OVERRUN]) begin
         overrun_d = 1'b0;
      end
      if (wr_stb && bus.address == ADDR_DONE && bus.writedata[0]) begin
         done_d = 1'b0;
      end
   end

   always_comb begin
      readdata_d = '0;
      case (bus.address)
         ADDR_DATA: readdata_d[DATA_BITS-1:0] = hold_q;
         ADDR_STATUS: begin
            readdata_d[STAT_BUSY]       = ser_busy;
            readdata_d[STAT_HOLD_EMPTY] = ~hold_full_q;
            readdata_d[STAT_OVERRUN]    = overrun_q;
         end
         ADDR_DONE: readdata_d[0] = done_q;
         default: readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         overrun_q   <= 1'b0;
         done_q      <= 1'b0;
         readdata_q  <= '0;
      end else begin
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         overrun_q   <= overrun_d;
         done_q      <= done_d;
         readdata_q  <= readdata_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_pio.sv
// Purpose: self-checking bench for uart_tx_pio with CLKS_PER_BIT=4.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled 1-2 units after.
// Backpressure: n/a.
module tb_uart_tx_pio;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic out_port;

   uart_tx_pio_if bus();

   uart_tx_pio #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .out_port (out_port)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic [7:0]  sb_q[$];
   int          start_q[$];
   int          edges = 0;
   bit          in_frame = 1'b0;
   logic        mon_last = 1'b1;
   int          mon_k = 0;
   logic [39:0] mon_w = '1;

   typedef struct {
      logic        cs;
      logic        wn;
      logic [1:0]  addr;
      logic [31:0] wd;
      logic [31:0] exp;
      bit          push;
   } vec_t;

   vec_t vt[14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected out_port samples of one frame: 4 start, 8x4 data LSB first, 4 stop.
   function automatic logic [39:0] frame_wave(input logic [7:0] b);
      logic [39:0] w;
      w = '1;
      for (int i = 0; i < CPB; i++) w[i] = 1'b0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < CPB; j++) w[CPB + CPB*i + j] = b[i];
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic cs, input logic wn, input logic [1:0] a, input logic [31:0] wd);
      bus.chipselect = cs;
      bus.write_n    = wn;
      bus.address    = a;
      bus.writedata  = wd;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] wd);
      drive(1'b1, 1'b0, a, wd);
      step();
      drive(1'b0, 1'b1, a, 32'h0);
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) step();
   endtask

   task automatic wait_start(input int n0, output int s);
      int t;
      t = 0;
      while (start_q.size() <= n0 && t < 200) begin
         step();
         t++;
      end
      if (start_q.size() > n0) begin
         s = start_q[n0];
      end else begin
         chk("start_timeout", 64'd0, 64'd1);
         s = cyc;
      end
   endtask

   // Idle means: not busy, holding empty, no overrun, monitor quiet, scoreboard drained.
   task automatic wait_idle();
      int  t;
      bit  ok;
      t  = 0;
      ok = 1'b0;
      drive(1'b0, 1'b1, 2'd1, 32'h0);
      while (!ok && t < 400) begin
         step();
         t++;
         ok = (bus.readdata == 32'h2) && !in_frame && (sb_q.size() == 0);
      end
      if (!ok) chk("idle_timeout", 64'd0, 64'd1);
   endtask

   task automatic clear_done();
      wr(2'd3, 32'h1);
      drive(1'b0, 1'b1, 2'd3, 32'h0);
      step();
      chk("done_clear", 64'(bus.readdata), 64'h0);
   endtask

   // Line monitor: captures each frame sample-by-sample and checks it against the scoreboard.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (out_port !== mon_last) edges++;
         mon_last = out_port;
         if (reset) begin
            in_frame = 1'b0;
         end else if (!in_frame) begin
            if (out_port === 1'b0) begin
               in_frame = 1'b1;
               mon_w    = '1;
               mon_w[0] = 1'b0;
               mon_k    = 1;
               start_q.push_back(cyc);
            end
         end else begin
            mon_w[mon_k] = out_port;
            mon_k++;
            if (mon_k == 40) begin
               in_frame = 1'b0;
               if (sb_q.size() == 0) chk("unexpected_frame", 64'(mon_w), 64'h0);
               else                  chk("frame", 64'(mon_w), 64'(frame_wave(sb_q.pop_front())));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int s, d, n0, n1, e0;

      // cs, wn, addr, wd, expected readdata (state before this edge), push to scoreboard
      vt[0]  = '{1'b0, 1'b1, 2'd0, 32'h00, 32'h0,  1'b0};
      vt[1]  = '{1'b0, 1'b1, 2'd1, 32'h00, 32'h2,  1'b0};
      vt[2]  = '{1'b0, 1'b1, 2'd2, 32'h00, 32'h0,  1'b0};
      vt[3]  = '{1'b0, 1'b1, 2'd3, 32'h00, 32'h0,  1'b0};
      vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h99, 32'h0,  1'b0};
      vt[5]  = '{1'b0, 1'b1, 2'd0, 32'h00, 32'h0,  1'b0};
      vt[6]  = '{1'b1, 1'b0, 2'd0, 32'hA5, 32'h0,  1'b1};
      vt[7]  = '{1'b1, 1'b0, 2'd0, 32'h3C, 32'hA5, 1'b1};
      vt[8]  = '{1'b1, 1'b0, 2'd0, 32'h77, 32'h3C, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 2'd1, 32'h00, 32'h5,  1'b0};
      vt[10] = '{1'b0, 1'b1, 2'd0, 32'h00, 32'h3C, 1'b0};
      vt[11] = '{1'b1, 1'b0, 2'd1, 32'h04, 32'h5,  1'b0};
      vt[12] = '{1'b0, 1'b1, 2'd1, 32'h00, 32'h1,  1'b0};
      vt[13] = '{1'b0, 1'b1, 2'd2, 32'h00, 32'h0,  1'b0};

      drive(1'b0, 1'b1, 2'd0, 32'h0);
      repeat (3) step();
      chk("rst_out_port", 64'(out_port), 64'h1);
      chk("rst_readdata", 64'(bus.readdata), 64'h0);
      reset = 1'b0;

      // Register map, chipselect gating, same-edge accept, overrun and its clear.
      for (int i = 0; i < 14; i++) begin
         drive(vt[i].cs, vt[i].wn, vt[i].addr, vt[i].wd);
         if (vt[i].push) sb_q.push_back(vt[i].wd[7:0]);
         step();
         chk($sformatf("vec%0d", i), 64'(bus.readdata), 64'(vt[i].exp));
      end
      drive(1'b0, 1'b1, 2'd0, 32'h0);
      wait_idle();
      if (start_q.size() >= 2) chk("vec_gap", 64'(start_q[1] - start_q[0]), 64'd41);
      else                     chk("vec_frames", 64'(start_q.size()), 64'd2);

      // Two frames, second written while the first is on the line.
      n0 = start_q.size();
      sb_q.push_back(8'hA3);
      wr(2'd0, 32'hA3);
      repeat (10) step();
      sb_q.push_back(8'h0F);
      wr(2'd0, 32'h0F);
      wait_idle();
      if (start_q.size() >= n0 + 2) chk("t2_gap", 64'(start_q[n0+1] - start_q[n0]), 64'd41);
      else                          chk("t2_frames", 64'(start_q.size() - n0), 64'd2);
      step();
      chk("t2_status", 64'(bus.readdata), 64'h2);
      clear_done();

      // Single frame: start delay and done flag timing.
      n0 = start_q.size();
      drive(1'b0, 1'b1, 2'd3, 32'h0);
      d = cyc;
      sb_q.push_back(8'h55);
      drive(1'b1, 1'b0, 2'd0, 32'h55);
      step();
      drive(1'b0, 1'b1, 2'd3, 32'h0);
      wait_start(n0, s);
      chk("t1_start_delay", 64'(s - d), 64'd2);
      wait_cyc(s + 38);
      chk("t1_done_early", 64'(bus.readdata), 64'h0);
      // done sets at start+40; registered read shows it one edge later.
      wait_cyc(s + 41);
      chk("t1_done", 64'(bus.readdata), 64'h1);
      wait_idle();
      clear_done();

      // Clear of done on the very edge it would set.
      n0 = start_q.size();
      sb_q.push_back(8'h5A);
      wr(2'd0, 32'h5A);
      wait_start(n0, s);
      wait_cyc(s + 39);
      drive(1'b1, 1'b0, 2'd3, 32'h1);
      step();
      drive(1'b0, 1'b1, 2'd3, 32'h0);
      step();
      chk("t5_clear_wins", 64'(bus.readdata), 64'h0);
      step();
      chk("t5_done_stays", 64'(bus.readdata), 64'h0);
      wait_idle();

      // Reads of addr2 and of a byte held while busy.
      n0 = start_q.size();
      sb_q.push_back(8'h81);
      wr(2'd0, 32'h81);
      wait_start(n0, s);
      wait_cyc(s + 5);
      drive(1'b0, 1'b1, 2'd2, 32'h0);
      step();
      chk("t6_addr2", 64'(bus.readdata), 64'h0);
      sb_q.push_back(8'hC7);
      drive(1'b1, 1'b0, 2'd0, 32'hC7);
      step();
      drive(1'b0, 1'b1, 2'd0, 32'h0);
      step();
      chk("t6_addr0", 64'(bus.readdata), 64'hC7);
      wait_idle();

      // Reset during data bit 3 aborts the frame and empties the holding register.
      n0 = start_q.size();
      sb_q.push_back(8'hF0);
      wr(2'd0, 32'hF0);
      wait_start(n0, s);
      sb_q.push_back(8'h11);
      wr(2'd0, 32'h11);
      wait_cyc(s + 17);
      reset = 1'b1;
      step();
      chk("t4_out_port", 64'(out_port), 64'h1);
      chk("t4_readdata", 64'(bus.readdata), 64'h0);
      step();
      reset = 1'b0;
      sb_q.delete();
      drive(1'b0, 1'b1, 2'd1, 32'h0);
      step();
      chk("t4_status", 64'(bus.readdata), 64'h2);
      drive(1'b0, 1'b1, 2'd3, 32'h0);
      step();
      chk("t4_done", 64'(bus.readdata), 64'h0);
      e0 = edges;
      n1 = start_q.size();
      repeat (60) step();
      chk("t4_no_edges", 64'(edges - e0), 64'd0);
      chk("t4_no_frames", 64'(start_q.size() - n1), 64'd0);
      chk("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
